count_issuer: RTL

COUNT_ISSUER -- requirements
Module: count_issuer

---
 rtl/counter_pkg.sv | 14 +
 rtl/count_job_fifo.sv | 66 ++++++
 rtl/count_issuer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the count issuer: FSM state encoding, default count
// width and the WAIT timeout margin.
package counter_pkg;

   localparam int unsigned DEFAULT_CNT_WIDTH = 7;
   localparam int unsigned TIMEOUT_MARGIN    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10
   } state_t;

endpackage

// File: rtl/count_job_fifo.sv
// Job queue for the count issuer: FIFO of requested count lengths; push and
// pop in the same cycle both take effect.
module count_job_fifo
   import counter_pkg::*;
#(
   parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [CNT_WIDTH-1:0] push_data,
   input  logic                 pop,
   output logic                 full,
   output logic                 empty,
   output logic [CNT_WIDTH-1:0] head
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [CNT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 do_push;
   logic                 do_pop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1))
         return '0;
      else
         return p + 1'b1;
   endfunction

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)
            rd_ptr <= next_ptr(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/count_issuer.sv
// Issues queued count jobs to an external counter FSM and tracks its progress.
// Optional WAIT timeout with sticky err_o is enabled by COUNT_ISSUER_TIMEOUT_EN.
module count_issuer
   import counter_pkg::*;
#(
   parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [CNT_WIDTH-1:0] req_cnt_i,
   output logic                 start_o,
   output logic [CNT_WIDTH-1:0] cnt_val_o,
   output logic [CNT_WIDTH-1:0] cnt_o,
   input  logic                 idle_i,
   input  logic                 run_i,
   input  logic                 done_i,
   output logic                 busy_o,
   output logic                 job_done_o,
   output logic                 job_skip_o,
   output logic                 err_o
);

   state_t               state;
   state_t               next_state;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_WIDTH-1:0] fifo_head;
   logic                 can_issue;
   logic                 can_skip;
   logic                 timeout_hit;

   count_job_fifo #(
      .CNT_WIDTH  (CNT_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_valid_i),
      .push_data (req_cnt_i),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign req_ready_o = !fifo_full;

   // Zero-length heads are skipped even while the counter is busy elsewhere.
   assign can_issue = !fifo_empty && (fifo_head != '0) && idle_i;
   assign can_skip  = !fifo_empty && (fifo_head == '0);

`ifdef COUNT_ISSUER_TIMEOUT_EN
   localparam int unsigned        WAIT_W     = CNT_WIDTH + 2;
   localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'((2 ** CNT_WIDTH) + TIMEOUT_MARGIN);

   logic [WAIT_W-1:0] wait_cnt;
   logic              err_q;

   // wait_cnt indexes the current WAIT cycle from 0; the last allowed one is LIMIT-1.
   assign timeout_hit = (state == WAIT) && !done_i && (wait_cnt == WAIT_LIMIT - 1'b1);

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == WAIT)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (timeout_hit)
            err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err_o       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (can_issue) next_state = ISSUE;
         ISSUE:   next_state = WAIT;
         WAIT:    if (done_i || timeout_hit) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are forced low while rst is high so nothing escapes during reset.
   always_comb begin
      fifo_pop   = 1'b0;
      start_o    = 1'b0;
      job_done_o = 1'b0;
      job_skip_o = 1'b0;
      busy_o     = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               fifo_pop   = can_issue || can_skip;
               job_done_o = can_skip;
               job_skip_o = can_skip;
            end
            ISSUE:   start_o    = 1'b1;
            WAIT:    job_done_o = done_i;
            default: ;
         endcase
         busy_o = (state != IDLE) || !fifo_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_o     <= '0;
         cnt_val_o <= '0;
      end else begin
         if (state == IDLE && can_issue)
            cnt_val_o <= fifo_head;
         if (state == ISSUE)
            cnt_o <= '0;
         else if (state == WAIT && run_i)
            cnt_o <= cnt_o + 1'b1;
      end
   end

endmodule
